// File: rtl/alu_arb_pkg.sv
// Shared constants for the EX-stage ALU arbiter: ALU op codes and default width.
// The external ALU decode uses the same op-code constants.
package alu_arb_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned OP_W         = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or above the
// pointer (modulo N); the pointer moves just past the winner when advance is set.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] eligible,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic [31:0]   ptr_ext;
  logic [31:0]   scan;
  logic          found;

  assign ptr_ext = 32'(ptr);

  always_comb begin
    grant = '0;
    pick  = '0;
    found = 1'b0;
    scan  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan = ptr_ext + k;
      if (scan >= N) scan = scan - N;
      if (!found && eligible[scan[PW-1:0]]) begin
        found                = 1'b1;
        grant[scan[PW-1:0]]  = 1'b1;
        pick                 = scan[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (32'(pick) == N - 1) ? '0 : pick + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters with round-robin
// arbitration; each result is held per requester until it is taken.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_op,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [NREQ*XLEN-1:0] rsp_data,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [3:0]           alu_op,
  output logic                 alu_rs2_imm,
  input  logic [XLEN-1:0]      alu_result
);

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] fire;

  // A full slot counts as free when it drains this cycle; nothing is granted in reset.
  assign eligible = req_valid & (~rsp_valid | rsp_ready) & {NREQ{rst_n}};
  assign fire      = grant & req_valid;
  assign req_ready = grant;
  assign alu_rs2_imm = 1'b0;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .advance  (|fire),
    .grant    (grant)
  );

  // Grant is one-hot or zero, so an OR-mux gives zeros when idle.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_a  = alu_a  | req_a[i*XLEN +: XLEN];
        alu_b  = alu_b  | req_b[i*XLEN +: XLEN];
        alu_op = alu_op | req_op[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (fire[i]) begin
          rsp_valid[i]               <= 1'b1;
          rsp_data[i*XLEN +: XLEN]   <= alu_result;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a reference ALU drives alu_result, and a
// transaction-level model of grants and held responses is checked every cycle.
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int XL = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*XL-1:0] req_a = '0;
  logic [N*XL-1:0] req_b = '0;
  logic [N*4-1:0]  req_op = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [N*XL-1:0] rsp_data;
  logic [XL-1:0]   alu_a, alu_b, alu_result;
  logic [3:0]      alu_op;
  logic            alu_rs2_imm;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  alu_arbiter #(.XLEN(XL), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_rs2_imm(alu_rs2_imm), .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // The ALU sitting behind the arbiter.
  always_comb alu_result = ref_alu(alu_op, alu_a, alu_b);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: next-in-line requester, held-result flags and values.
  int          m_ptr = 0;
  bit [N-1:0]  m_v = '0;
  logic [31:0] m_d [N] = '{default: 32'd0};

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (rst_n === 1'b1 && req_valid[j] && (!m_v[j] || rsp_ready[j])) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_ptr = 0;
      m_v   = '0;
      for (int i = 0; i < N; i++) m_d[i] = 32'd0;
    end else begin
      g = exp_grant();
      for (int i = 0; i < N; i++) if (m_v[i] && rsp_ready[i]) m_v[i] = 1'b0;
      if (g >= 0) begin
        m_v[g] = 1'b1;
        m_d[g] = ref_alu(req_op[g*4 +: 4], req_a[g*XL +: XL], req_b[g*XL +: XL]);
        m_ptr  = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0]    e_rdy;
    logic [N*XL-1:0] e_dat;
    logic [31:0]     e_a, e_b;
    logic [3:0]      e_op;
    if (chk_on) begin
      g = exp_grant();
      e_rdy = '0; e_a = '0; e_b = '0; e_op = '0;
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        e_a  = req_a[g*XL +: XL];
        e_b  = req_b[g*XL +: XL];
        e_op = req_op[g*4 +: 4];
      end
      for (int i = 0; i < N; i++) e_dat[i*XL +: XL] = m_d[i];
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("alu_a", 64'(alu_a), 64'(e_a));
      chk("alu_b", 64'(alu_b), 64'(e_b));
      chk("alu_op", 64'(alu_op), 64'(e_op));
      chk("alu_rs2_imm", 64'(alu_rs2_imm), 64'd0);
      chk("rsp_valid", 64'(rsp_valid), 64'(m_v));
      chk("rsp_data", 64'(rsp_data), 64'(e_dat));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, bit v, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    req_valid[i]        = v;
    req_a[i*XL +: XL]   = a;
    req_b[i*XL +: XL]   = b;
    req_op[i*4 +: 4]    = op;
  endtask

  initial begin
    logic [N-1:0] seq [4];
    bit found;
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 1'b0;
    tick();
    chk_on = 1;
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_data", 64'(rsp_data), 64'd0);
    chk("reset alu_a", 64'(alu_a), 64'd0);
    tick();
    rst_n = 1'b1;

    // Contention: strict alternation from requester 0.
    set_req(0, 1, 32'd10, 32'd3, 4'd1);
    set_req(1, 1, 32'hF0, 32'h0F, 4'd4);
    rsp_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("contention grant", 64'(req_ready), 64'(seq[c]));
      tick();
    end
    chk("contention sub", 64'(rsp_data[31:0]), 64'd7);
    chk("contention xor", 64'(rsp_data[63:32]), 64'hFF);
    req_valid = '0;
    tick();

    // Single request, one-cycle latency, then drained.
    set_req(0, 1, 32'd5, 32'd7, 4'd0);
    #1;
    chk("single ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    #1;
    chk("single valid", 64'(rsp_valid[0]), 64'd1);
    chk("single data", 64'(rsp_data[31:0]), 64'd12);
    tick();
    chk("single popped", 64'(rsp_valid[0]), 64'd0);
    chk("single hold", 64'(rsp_data[31:0]), 64'd12);

    // Backpressure on requester 1.
    rsp_ready = 2'b01;
    set_req(1, 1, 32'd100, 32'd1, 4'd0);
    tick();
    set_req(1, 1, 32'h30, 32'h03, 4'd3);
    set_req(0, 1, 32'd1, 32'd2, 4'd0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp grant0", 64'(req_ready), 64'b01);
      chk("bp hold1", 64'(rsp_data[63:32]), 64'h65);
      tick();
    end
    rsp_ready = 2'b11;
    found = 0;
    for (int c = 0; c < 2 && !found; c++) begin
      #1;
      found = req_ready[1];
      tick();
    end
    req_valid = '0;
    chk("bp req1 granted", 64'(found), 64'd1);
    #1;
    chk("bp new data1", 64'(rsp_data[63:32]), 64'h33);
    tick();

    // Same-cycle pop and refill on requester 0.
    rsp_ready = 2'b00;
    set_req(0, 1, 32'd1, 32'd1, 4'd0);
    tick();
    set_req(0, 1, 32'hFF, 32'h3C, 4'd2);
    rsp_ready = 2'b01;
    #1;
    chk("refill ready", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    #1;
    chk("refill valid", 64'(rsp_valid[0]), 64'd1);
    chk("refill data", 64'(rsp_data[31:0]), 64'h3C);

    // Wrap-around ADD and unsupported op code.
    rsp_ready = 2'b11;
    set_req(0, 1, 32'hFFFF_FFFF, 32'd1, 4'd0);
    tick();
    req_valid = '0;
    #1;
    chk("wrap data", 64'(rsp_data[31:0]), 64'd0);
    set_req(1, 1, 32'd5, 32'd6, 4'd9);
    tick();
    req_valid = '0;
    #1;
    chk("op9 valid", 64'(rsp_valid[1]), 64'd1);
    chk("op9 data", 64'(rsp_data[63:32]), 64'd0);
    tick();

    // Async reset with both slots full.
    rsp_ready = 2'b00;
    set_req(0, 1, 32'd2, 32'd2, 4'd0);
    set_req(1, 1, 32'd3, 32'd3, 4'd0);
    tick();
    tick();
    chk("full both", 64'(rsp_valid), 64'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async valid clr", 64'(rsp_valid), 64'd0);
    chk("async data clr", 64'(rsp_data), 64'd0);
    chk("reset no grant", 64'(req_ready), 64'd0);
    tick();
    tick();
    rsp_ready = 2'b11;
    rst_n = 1'b1;
    #1;
    chk("post reset grant", 64'(req_ready), 64'b01);
    tick();
    tick();
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle EX-stage ALU between up to NREQ requesters (e.g. the main pipeline and an address/branch helper) using round-robin arbitration with valid/ready handshakes. Each granted request drives the ALU for exactly one cycle. The result is captured into a per-requester response register that holds it until the requester accepts it. The block sits between the requesters and the ALU and is the only driver of the ALU's inputs.

## Interface
- XLEN, 32, operand/result width
- NREQ, 2, number of requesters (2..8)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_a  in  NREQ*XLEN  operand A, slice i = [i*XLEN +: XLEN]
- req_b  in  NREQ*XLEN  operand B (requester has already muxed rs2/imm)
- req_op  in  NREQ*4  ALU op code, slice i = [i*4 +: 4]
- rsp_valid  out  NREQ  result held for requester i
- rsp_ready  in  NREQ  requester i takes its result
- rsp_data  out  NREQ*XLEN  held result per requester
- alu_a  out  XLEN  to ALU rs1_data
- alu_b  out  XLEN  to ALU rs2_data
- alu_op  out  4  to ALU alu_op
- alu_rs2_imm  out  1  constant 0 (operand B always taken from alu_b)
- alu_result  in  XLEN  from ALU, combinational in same cycle

## Operation
- Eligibility: requester i is eligible when req_valid[i] & (~rsp_valid[i] | rsp_ready[i]), so a full slot may be refilled in the cycle it drains.
- Selection: scan from rr_ptr upward modulo NREQ and pick the first eligible requester. At most one grant per cycle. req_ready = grant one-hot (may depend on req_valid).
- ALU drive: on a grant, alu_a/alu_b/alu_op = granted requester's slices. With no grant, drive all zero (op 0 = ADD, result ignored).
- Fire (req_valid[i] & req_ready[i]): rsp_data[i] <= alu_result, rsp_valid[i] <= 1, rr_ptr <= (i+1) mod NREQ.
- Pop (rsp_valid[i] & rsp_ready[i] with no new fire for i): rsp_valid[i] <= 0. rsp_data[i] holds its last value.
- Pop and fire in the same cycle for the same i: rsp_valid stays 1 and the data is replaced.
- rr_ptr is unchanged on cycles with no grant.
- Op codes are passed through unchecked: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR. Codes 5..15 yield 0 from the ALU and are still returned as a normal response.
- Arithmetic wraps modulo 2^XLEN. There is no overflow flag.

## Timing
- Reset (async assert, sync release): rsp_valid = 0, rsp_data = 0, rr_ptr = 0. ALU outputs are zero whenever req_valid = 0.
- Reset mid-operation: held results are discarded and no grant is issued while rst_n = 0.
- Latency: request fire in cycle N gives rsp_valid = 1 with data in cycle N+1.
- Throughput: one operation per cycle aggregate. Each requester can sustain one per cycle if it pops every cycle.
- Fairness: a continuously eligible requester is granted within NREQ cycles.
- req_a/req_b/req_op must stay stable while req_valid = 1 and req_ready = 0. Requesters must not drop req_valid before it is accepted.
- rsp_data/rsp_valid change only on clock edges. They are never combinational from inputs.

## Structure
- Package alu_arb_pkg: op-code localparams (ALU_ADD=4'd0, ALU_SUB=4'd1, ALU_AND=4'd2, ALU_OR=4'd3, ALU_XOR=4'd4) and the default XLEN. The ALU decode shares these constants.
- Sub-module rr_arbiter, parameterized by N, holds the pointer register and the first-eligible-from-pointer pick:
  - in: clk, rst_n, eligible[N], advance
  - out: grant one-hot
- alu_arbiter instantiates rr_arbiter and contains the operand mux, the response registers and the eligibility logic.

## Test plan
- Single request: after reset, req0 ADD a=5 b=7 with rsp_ready0 = 1 -> req_ready0 same cycle, rsp_valid0 = 1 with rsp_data0 = 12 next cycle, then rsp_valid0 = 0.
- Contention: both requesters valid continuously with rsp_ready = 1, req0 SUB 10-3, req1 XOR 0xF0^0x0F -> grants alternate 0,1,0,1 starting at 0. Results are 7 and 0xFF.
- Backpressure: rsp_ready1 = 0 with rsp_valid1 set and req1 valid -> req1 is never granted and req0 receives every grant. Raising rsp_ready1 makes req1 eligible and it is granted within 2 cycles, while rsp_data1 holds its old value until replaced.
- Same-cycle pop and refill: rsp_valid0 = 1, rsp_ready0 = 1 and req0 AND 0xFF&0x3C granted -> rsp_valid0 stays 1 and data becomes 0x3C.
- Wrap and unsupported op: ADD 0xFFFFFFFF+1 -> 0. op = 4'd9 -> response 0 delivered normally.
- Async reset asserted while rsp_valid = 2'b11 -> outputs clear immediately without waiting for a clock edge. After release, the first grant goes to req0 when both requesters are valid.
